// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester (fetch / load-store) arbiter onto one shared
// SRAM-like port with address-phase backpressure and in-order responses.
// Optional feature macro: SRAM_ARB_RR_EN selects round-robin arbitration on
// ties; without it load/store always beats fetch.
module sram_arbiter #(
  parameter int MAX_OUTSTANDING = 2  // accepted-but-unanswered limit, 1..4
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;
  typedef enum logic {SRC_INST, SRC_DATA} src_e;

  state_e      state_q, state_d;
  src_e        hold_src_q, hold_src_d;
  src_e        idle_grant;
  src_e        grant;
  logic        active;
  logic        full;
  logic        push;
  logic        pop;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  src_e        tag_fifo_q [4];

`ifdef SRAM_ARB_RR_EN
  src_e        rr_last_q;
`endif

  // Pointer advance with wrap at the configured depth, not the storage size.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Winner when no grant is frozen: tie policy depends on the build.
  always_comb begin
    idle_grant = data_req ? SRC_DATA : SRC_INST;
`ifdef SRAM_ARB_RR_EN
    if (inst_req && data_req) begin
      idle_grant = (rr_last_q == SRC_DATA) ? SRC_INST : SRC_DATA;
    end
`endif
  end

  // FSM next state, grant selection, handshakes and shared-port fields.
  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first so no latch is inferred; clocked state below uses '<=' only.
  always_comb begin
    state_d    = state_q;
    hold_src_d = hold_src_q;
    grant      = idle_grant;
    active     = inst_req | data_req;

    if (state_q == ST_HOLD) begin
      // Grant frozen until the port accepts, even if the requester misbehaves.
      grant  = hold_src_q;
      active = 1'b1;
    end

    // Limit uses the count before any same-cycle pop.
    full    = (count_q == 3'(MAX_OUTSTANDING));
    mem_req = resetn & active & ~full;
    push    = mem_req & mem_addr_ok;
    pop     = resetn & mem_data_ok & (count_q != 3'd0);

    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_d    = ST_HOLD;
          hold_src_d = idle_grant;
        end
      end
      ST_HOLD: begin
        if (push) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    inst_addr_ok = push & (grant == SRC_INST);
    data_addr_ok = push & (grant == SRC_DATA);

    if (grant == SRC_DATA) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = 1'b0;
      mem_wstrb = 4'h0;
      mem_addr  = inst_addr;
      mem_wdata = 32'h0;
    end

    inst_data_ok = pop & (tag_fifo_q[rd_ptr_q] == SRC_INST);
    data_data_ok = pop & (tag_fifo_q[rd_ptr_q] == SRC_DATA);

    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  // Response data goes to both requesters; data_ok says who owns it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // Control state: FSM, outstanding count, FIFO pointers, tie pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      hold_src_q <= SRC_INST;
      count_q    <= 3'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
`ifdef SRAM_ARB_RR_EN
      rr_last_q  <= SRC_INST;
`endif
    end else begin
      state_q    <= state_d;
      hold_src_q <= hold_src_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
`ifdef SRAM_ARB_RR_EN
      if (push) rr_last_q <= grant;
`endif
    end
  end

  // Tag storage for in-order response routing.
  // NOTE: the tag array has no reset; pointers and count define which
  // entries are live, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) tag_fifo_q[wr_ptr_q] <= grant;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, giving accepted-but-unanswered requests allowed, legal range 1..4.
REQ-002 SHALL have port clk  in  1  single clock; all state rises on posedge clk.
REQ-003 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port inst_req  in  1  fetch read request.
REQ-005 SHALL have port inst_addr  in  32  fetch address.
REQ-006 SHALL have port inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 SHALL have port inst_data_ok  out  1  fetch read data valid this cycle.
REQ-008 SHALL have port inst_rdata  out  32  fetch read data.
REQ-009 SHALL have port data_req  in  1  load/store request.
REQ-010 SHALL have port data_wr  in  1  1=write, 0=read.
REQ-011 SHALL have port data_wstrb  in  4  write byte strobes.
REQ-012 SHALL have port data_addr  in  32  load/store address.
REQ-013 SHALL have port data_wdata  in  32  store data.
REQ-014 SHALL have port data_addr_ok  out  1  load/store request accepted.
REQ-015 SHALL have port data_data_ok  out  1  load data returned or store completed.
REQ-016 SHALL have port data_rdata  out  32  load data.
REQ-017 SHALL have port mem_req  out  1  shared-port request.
REQ-018 SHALL have ports mem_wr (1), mem_wstrb (4), mem_addr (32), mem_wdata (32)  out  shared-port request fields.
REQ-019 SHALL have port mem_addr_ok  in  1  shared port accepted request.
REQ-020 SHALL have port mem_data_ok  in  1  shared port response valid.
REQ-021 SHALL have port mem_rdata  in  32  shared port response data.

Function
REQ-022 SHALL forward the granted requester's fields to mem_*; inst grant drives mem_wr=0, mem_wstrb=4'h0, mem_wdata=32'h0.
REQ-023 SHALL run FSM IDLE/HOLD: IDLE selects a grant combinationally; HOLD entered when mem_req=1 and mem_addr_ok=0, freezing grant until mem_addr_ok=1 (address/data stable under backpressure).
REQ-024 SHALL assert X_addr_ok = mem_addr_ok & mem_req & (grant==X), same cycle, zero added latency; never both addr_ok in one cycle.
REQ-025 SHALL keep outstanding count 0..MAX_OUTSTANDING; mem_req forced 0 when count==MAX_OUTSTANDING (pre-pop value, no same-cycle bypass).
REQ-026 SHALL push the grant tag into an in-order tag FIFO (depth MAX_OUTSTANDING) on mem_req&mem_addr_ok, pop on mem_data_ok; simultaneous push/pop leaves count unchanged.
REQ-027 SHALL route mem_data_ok to inst_data_ok or data_data_ok per FIFO head tag, same cycle; mem_rdata broadcast to both rdata outputs.
REQ-028 SHALL ignore mem_data_ok when FIFO empty (no data_ok, count stays 0).
REQ-029 SHALL deassert mem_req when neither requester is active and in IDLE; a requester dropping req in HOLD is a protocol error, grant still held.
REQ-030 SHALL cap count arithmetic at 3 bits, no wrap; FIFO pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-031 SHALL on resetn=0 immediately clear FSM to IDLE, count to 0, FIFO pointers to 0, round-robin pointer to inst; all *_addr_ok, *_data_ok, mem_req read 0; in-flight transactions discarded.
REQ-032 SHALL accept first request the cycle after resetn deasserts.

Configuration
REQ-033 SHALL, with SRAM_ARB_RR_EN defined, arbitrate round-robin: last-granted requester loses a tie, pointer updated on each mem_addr_ok.
REQ-034 SHALL, without SRAM_ARB_RR_EN, give data fixed priority over inst on ties.

Verification
REQ-035 SHALL cover: inst_req only, addr 0x1c000000, mem_addr_ok=1, mem_data_ok next cycle rdata 0x02800c0c -> inst_addr_ok cycle 0, inst_data_ok cycle 1 with 0x02800c0c.
REQ-036 SHALL cover: both req every cycle, mem_addr_ok=1 always, responses one cycle later -> fixed mode: data granted every cycle; RR mode: grants alternate D,I,D,I.
REQ-037 SHALL cover: data store 0x1c0100f0 wstrb 4'hf, mem_addr_ok low 3 cycles while inst_req rises -> mem_addr/wdata stable 3 cycles, inst not granted until store accepted.
REQ-038 SHALL cover: MAX_OUTSTANDING=2, two reads accepted, no mem_data_ok -> mem_req 0; one mem_data_ok -> mem_req 1 next cycle, responses tagged in issue order.
REQ-039 SHALL cover: resetn pulsed low with 2 outstanding -> outputs 0 asynchronously, later mem_data_ok ignored, count 0.
